// File: rtl/reg_file_sb.sv
// Multi-port register file with write-to-read bypass, hardwired zero register,
// stack-pointer reset value and a per-register pending-write scoreboard.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_IDX   = 29,
    parameter int SP_INIT  = 128,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] ra_addr_i,
    input  logic [ADDR_W-1:0] rb_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    output logic [DATA_W-1:0] rb_data_o,
    output logic              ra_busy_o,
    output logic              rb_busy_o,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] wa0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] wa1_i,
    input  logic [DATA_W-1:0] wd1_i,
    input  logic              iss_i,
    input  logic [ADDR_W-1:0] iss_addr_i,
    output logic              iss_ok_o
);

    localparam int              NREGS    = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);
    localparam logic            HAS_ZERO = (ZERO_REG != 0);
    localparam logic            HAS_BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  pend_q;
    logic [NREGS-1:0]  pend_d;
    logic [NREGS-1:0]  clr_vec;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return HAS_ZERO && (a == '0);
    endfunction

    // Port 1 is applied last so it overrides port 0 on an address match.
    function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] arr);
        logic [DATA_W-1:0] r;
        r = arr;
        if (HAS_BYP && we0_i && (wa0_i == a)) r = wd0_i;
        if (HAS_BYP && we1_i && (wa1_i == a)) r = wd1_i;
        if (is_zero(a)) r = '0;
        return r;
    endfunction

    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NREGS; i++) begin
            clr_vec[i] = (we0_i && (wa0_i == ADDR_W'(i))) || (we1_i && (wa1_i == ADDR_W'(i)));
        end
    end

    // Issue handshake: iss_i is a request held by decode until iss_ok_o is
    // seen high; the destination is marked pending only on a cycle with both.
    assign iss_ok_o  = is_zero(iss_addr_i) ? 1'b1 : (~pend_q[iss_addr_i] | clr_vec[iss_addr_i]);

    assign ra_data_o = read_mux(ra_addr_i, regs_q[ra_addr_i]);
    assign rb_data_o = read_mux(rb_addr_i, regs_q[rb_addr_i]);
    assign ra_busy_o = is_zero(ra_addr_i) ? 1'b0
                     : (pend_q[ra_addr_i] & ~(HAS_BYP & clr_vec[ra_addr_i]));
    assign rb_busy_o = is_zero(rb_addr_i) ? 1'b0
                     : (pend_q[rb_addr_i] & ~(HAS_BYP & clr_vec[rb_addr_i]));

    always_comb begin
        regs_d = regs_q;
        if (we0_i && !is_zero(wa0_i)) regs_d[wa0_i] = wd0_i;
        if (we1_i && !is_zero(wa1_i)) regs_d[wa1_i] = wd1_i;
    end

    // Set after clear: a new producer issuing on a retiring write owns the bit.
    always_comb begin
        pend_d = pend_q & ~clr_vec;
        if (iss_i && iss_ok_o) pend_d[iss_addr_i] = 1'b1;
        if (HAS_ZERO) pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RST : '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed steps from the plan, then random traffic
// compared against an array-based reference model of the register file.
module tb_reg_file_sb;

    logic        clk_i, rst_i;
    logic [4:0]  ra_addr_i, rb_addr_i, wa0_i, wa1_i, iss_addr_i;
    logic [31:0] ra_data_o, rb_data_o, wd0_i, wd1_i;
    logic        ra_busy_o, rb_busy_o, we0_i, we1_i, iss_i, iss_ok_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    logic        m_pend [32];
    logic [31:0] exp_q [$];

    reg_file_sb dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ra_addr_i(ra_addr_i), .rb_addr_i(rb_addr_i),
        .ra_data_o(ra_data_o), .rb_data_o(rb_data_o),
        .ra_busy_o(ra_busy_o), .rb_busy_o(rb_busy_o),
        .we0_i(we0_i), .wa0_i(wa0_i), .wd0_i(wd0_i),
        .we1_i(we1_i), .wa1_i(wa1_i), .wd1_i(wd1_i),
        .iss_i(iss_i), .iss_addr_i(iss_addr_i), .iss_ok_o(iss_ok_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_clr(input int a);
        return (we0_i && wa0_i == a) || (we1_i && wa1_i == a);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (we1_i && wa1_i == a) return wd1_i;
        if (we0_i && wa0_i == a) return wd0_i;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input int a);
        if (a == 0) return 1'b0;
        return m_pend[a] && !m_clr(a);
    endfunction

    function automatic logic m_iss_ok();
        if (iss_addr_i == 0) return 1'b1;
        return !m_pend[iss_addr_i] || m_clr(iss_addr_i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_regs[29] = 32'd128;
    endtask

    task automatic model_update();
        logic ok;
        ok = m_iss_ok();
        for (int i = 1; i < 32; i++) if (m_clr(i)) m_pend[i] = 1'b0;
        if (we0_i && wa0_i != 0) m_regs[wa0_i] = wd0_i;
        if (we1_i && wa1_i != 0) m_regs[wa1_i] = wd1_i;
        if (iss_i && ok && iss_addr_i != 0) m_pend[iss_addr_i] = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        we0_i = 0; we1_i = 0; iss_i = 0;
        wa0_i = 0; wa1_i = 0; wd0_i = 0; wd1_i = 0; iss_addr_i = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ra_data"}, ra_data_o, m_read(ra_addr_i));
        chk({tag, ".rb_data"}, rb_data_o, m_read(rb_addr_i));
        chk({tag, ".ra_busy"}, 32'(ra_busy_o), 32'(m_busy(ra_addr_i)));
        chk({tag, ".rb_busy"}, 32'(rb_busy_o), 32'(m_busy(rb_addr_i)));
        chk({tag, ".iss_ok"}, 32'(iss_ok_o), 32'(m_iss_ok()));
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_i) model_reset();
        else model_update();
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        ra_addr_i = 5'd29; rb_addr_i = 5'd5;
        rst_i = 1'b1;
        model_reset();
        #2;
        chk("rst.ra_sp", ra_data_o, 32'd128);
        chk("rst.rb_zero", rb_data_o, 32'd0);
        check_all("rst");
        tick();
        rst_i = 1'b0;
        tick();

        // Bypassed write, then array read next cycle
        we0_i = 1; wa0_i = 5'd3; wd0_i = 32'hDEADBEEF; ra_addr_i = 5'd3;
        @(negedge clk_i);
        chk("byp.ra", ra_data_o, 32'hDEADBEEF);
        check_all("byp");
        tick();
        idle();
        @(negedge clk_i);
        chk("arr.ra", ra_data_o, 32'hDEADBEEF);
        tick();

        // Both write ports to the same address: port 1 wins
        we0_i = 1; wa0_i = 5'd7; wd0_i = 32'd1;
        we1_i = 1; wa1_i = 5'd7; wd1_i = 32'd2; ra_addr_i = 5'd7;
        @(negedge clk_i);
        chk("conf.byp", ra_data_o, 32'd2);
        tick();
        idle();
        @(negedge clk_i);
        chk("conf.arr", ra_data_o, 32'd2);
        tick();

        // Zero register ignores writes and issues
        we0_i = 1; wa0_i = 5'd0; wd0_i = 32'h55; ra_addr_i = 5'd0;
        @(negedge clk_i);
        chk("zero.byp", ra_data_o, 32'd0);
        tick();
        idle(); iss_i = 1; iss_addr_i = 5'd0;
        @(negedge clk_i);
        chk("zero.iss_ok", 32'(iss_ok_o), 32'd1);
        tick();
        idle();
        @(negedge clk_i);
        chk("zero.busy", 32'(ra_busy_o), 32'd0);
        chk("zero.data", ra_data_o, 32'd0);
        tick();

        // Scoreboard: issue, stall, write-back clears
        iss_i = 1; iss_addr_i = 5'd9; ra_addr_i = 5'd9;
        @(negedge clk_i);
        chk("sb.iss1", 32'(iss_ok_o), 32'd1);
        tick();
        @(negedge clk_i);
        chk("sb.busy", 32'(ra_busy_o), 32'd1);
        chk("sb.stall", 32'(iss_ok_o), 32'd0);
        tick();
        idle(); we0_i = 1; wa0_i = 5'd9; wd0_i = 32'h10; iss_addr_i = 5'd9; ra_addr_i = 5'd9;
        @(negedge clk_i);
        chk("sb.wb_busy", 32'(ra_busy_o), 32'd0);
        chk("sb.wb_data", ra_data_o, 32'h10);
        chk("sb.wb_ok", 32'(iss_ok_o), 32'd1);
        tick();
        idle(); ra_addr_i = 5'd9;
        @(negedge clk_i);
        chk("sb.cleared", 32'(ra_busy_o), 32'd0);
        check_all("sb.after");
        tick();

        // Write-back and issue to the same register on one edge: set wins
        iss_i = 1; iss_addr_i = 5'd4; we1_i = 1; wa1_i = 5'd4; wd1_i = 32'hABCD;
        tick();
        idle(); ra_addr_i = 5'd4;
        @(negedge clk_i);
        chk("sim.busy", 32'(ra_busy_o), 32'd1);
        chk("sim.data", ra_data_o, 32'hABCD);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            we0_i = 1'($urandom_range(0, 1));
            we1_i = 1'($urandom_range(0, 1));
            iss_i = 1'($urandom_range(0, 1));
            wa0_i = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wa1_i = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            iss_addr_i = 5'($urandom_range(0, 7));
            ra_addr_i = 5'($urandom_range(0, 7));
            rb_addr_i = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wd0_i = $urandom;
            wd1_i = $urandom;
            @(negedge clk_i);
            check_all("rand");
            tick();
        end

        // Asynchronous reset between edges, held across an edge with a write active
        idle(); ra_addr_i = 5'd29; rb_addr_i = 5'd5;
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("arst.ra", ra_data_o, 32'd128);
        chk("arst.rb", rb_data_o, 32'd0);
        check_all("arst");
        we0_i = 1; wa0_i = 5'd6; wd0_i = 32'hFFFF; iss_i = 1; iss_addr_i = 5'd6;
        tick();
        idle(); ra_addr_i = 5'd6;
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("arst.prio_data", ra_data_o, 32'd0);
        chk("arst.prio_busy", 32'(ra_busy_o), 32'd0);
        tick();

        // Fill and read back through the expected queue
        for (int i = 10; i < 18; i++) begin
            logic [31:0] v;
            v = $urandom;
            idle(); we1_i = 1; wa1_i = 5'(i); wd1_i = v;
            exp_q.push_back(v);
            tick();
        end
        idle();
        for (int i = 10; i < 18; i++) begin
            ra_addr_i = 5'(i); rb_addr_i = 5'(i);
            @(negedge clk_i);
            chk("fill.ra", ra_data_o, exp_q.pop_front());
            check_all("fill");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-port register file for the pipelined CPU datapath. Provides two combinational read ports, two write-back ports, and optional write-to-read bypass. Includes a hardwired zero register, a configurable stack-pointer reset value, and a per-register pending-write scoreboard that decode uses for hazard stalls. It sits between the decode stage (reads and issue) and the write-back stage (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NREGS = 2**ADDR_W
SP_IDX, 29, index of the register that resets to SP_INIT
SP_INIT, 128, reset value of register SP_IDX, truncated to DATA_W
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and issues
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports

Ports:
clk_i  in  1  clock; all state updates on its rising edge
rst_i  in  1  reset, asynchronous, active-high
ra_addr_i  in  ADDR_W  read port A address
rb_addr_i  in  ADDR_W  read port B address
ra_data_o  out  DATA_W  read port A data
rb_data_o  out  DATA_W  read port B data
ra_busy_o  out  1  port A operand not yet valid
rb_busy_o  out  1  port B operand not yet valid
we0_i  in  1  write enable, port 0
wa0_i  in  ADDR_W  write address, port 0
wd0_i  in  DATA_W  write data, port 0
we1_i  in  1  write enable, port 1 (priority port)
wa1_i  in  ADDR_W  write address, port 1
wd1_i  in  DATA_W  write data, port 1
iss_i  in  1  issue request: mark iss_addr_i as pending
iss_addr_i  in  ADDR_W  destination register of the issuing instruction
iss_ok_o  out  1  issue accepted this cycle (0 = stall)

Behaviour:
- Reset (rst_i=1, asynchronous, any time including mid-operation):
  - All registers are cleared to 0, except register SP_IDX, which is set to SP_INIT.
  - All pending bits are cleared.
  - Outputs then follow the combinational rules below with the reset state: data outputs 0 (port at SP_IDX shows SP_INIT), busy 0, iss_ok_o 1.
  - Reset has priority over same-edge writes and issues.
- Writes (rising edge, rst_i=0):
  - reg[waN] <= wdN when weN=1.
  - Both ports enabled with the same address: port 1 wins.
  - ZERO_REG=1: writes to address 0 are discarded.
  - Write latency: visible on the array read path the next cycle.
- Reads (combinational, zero latency):
  - ZERO_REG=1 and address 0: returns 0.
  - Otherwise, if BYPASS=1 and we1/wa1 match the read address: returns wd1.
  - Otherwise, if BYPASS=1 and we0/wa0 match: returns wd0.
  - Otherwise: returns the array value.
- Scoreboard, one pending bit per register:
  - Set at the edge when iss_i=1 and iss_ok_o=1, for address iss_addr_i.
  - Clear at the edge for each address written by an enabled write port.
  - Set and clear of the same address on the same edge: set wins, because a new producer has issued.
  - ZERO_REG=1: bit 0 is never set.
- clr_x (combinational): (we0_i & wa0_i==x) | (we1_i & wa1_i==x).
- iss_ok_o = ~pending[iss_addr_i] | clr_x(iss_addr_i). Write-after-write stalls until the older write retires or is retiring this cycle. Address 0 with ZERO_REG=1 always returns 1.
- Busy flags:
  - BYPASS=1: rX_busy_o = pending[rX_addr] & ~clr_x(rX_addr).
  - BYPASS=0: rX_busy_o = pending[rX_addr].
  - Address 0 with ZERO_REG=1: always 0.
- A write to a non-pending register is legal: data is updated and the scoreboard is unchanged.
- Issue with iss_i=1 and iss_ok_o=0: no state change; the requester holds its request.
- Address width rules: all addresses are full ADDR_W bits; there is no out-of-range case.
- Data width rules: data is stored unsigned DATA_W; SP_INIT is truncated to DATA_W.

Test Plan:
- Reset: pulse rst_i mid-simulation between clock edges, with ra=29 and rb=5 -> outputs change immediately to ra_data_o=128, rb_data_o=0, both busy=0, iss_ok_o=1.
- Write/read: we0=1, wa0=3, wd0=0xDEADBEEF, with ra=3 -> same cycle ra_data_o=0xDEADBEEF (bypass). With BYPASS=0: previous value, then 0xDEADBEEF the next cycle.
- Port conflict: we0 and we1 both to address 7, with wd0=1 and wd1=2 -> reg7=2, and the bypassed read returns 2.
- Zero register: write 0x55 to address 0, then issue to address 0 -> ra_data_o=0 at address 0, iss_ok_o=1, busy=0 afterwards.
- Scoreboard:
  - Issue to address 9 -> next cycle: ra=9 gives busy=1; a second issue to 9 gives iss_ok_o=0.
  - Write-back of 9 with wd=0x10 -> same cycle: busy=0, data=0x10, iss_ok_o=1.
  - Next cycle: pending bit clear.
- Simultaneous: write-back to 4 and issue to 4 on the same edge -> pending[4]=1 afterwards, reg4 holds the written data, and ra=4 gives busy=1.
